// File: rtl/control_booth_r4.sv
// -----------------------------------------------------------------------------
// control_booth_r4
// Sequencer for a radix-4 Booth multiplier datapath. It has no arithmetic of
// its own. It accepts a start request and loads the operands (A cleared, Q and
// M loaded). It then runs N/2 recode / optional add / 2-bit shift iterations
// and pulses done when {A,Q} holds the product.
//
// Ports
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   start     in   multiply request, sampled only in IDLE
//   q_bits    in   {Q[1],Q[0],q_-1} from the datapath, valid in EVAL
//   clr_a     out  A loads zero (with carga_a) during LOAD
//   carga_a   out  A register load (LOAD and ADD)
//   carga_q   out  Q register load (LOAD)
//   carga_m   out  M register load (LOAD)
//   desplaza  out  2-bit arithmetic right shift of A,Q,q_-1 (SHIFT)
//   resta     out  1 = subtract (M|2M) from A, only in ADD
//   sel_m2    out  1 = 2M, 0 = M, only in ADD
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse in DONE
// -----------------------------------------------------------------------------
module control_booth_r4 #(
  parameter int N     = 4,
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] q_bits,
  output logic       clr_a,
  output logic       carga_a,
  output logic       carga_q,
  output logic       carga_m,
  output logic       desplaza,
  output logic       resta,
  output logic       sel_m2,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // op = {active, resta, sel_m2}; active=0 means no add this iteration
  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_PM  = 3'b100;
  localparam logic [2:0] OP_P2M = 3'b101;
  localparam logic [2:0] OP_MM  = 3'b110;
  localparam logic [2:0] OP_M2M = 3'b111;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N/2 - 1);

  logic [2:0]       r_state;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_count;
  logic [8:0]       r_outs;

  logic [2:0]       w_state_nxt;
  logic [2:0]       w_op_nxt;
  logic [CNT_W-1:0] w_count_nxt;

  // Radix-4 Booth recoding of the current bit triplet
  function automatic logic [2:0] recode(input logic [2:0] qb);
    logic [2:0] op;
    case (qb)
      3'b001, 3'b010: op = OP_PM;
      3'b011:         op = OP_P2M;
      3'b100:         op = OP_M2M;
      3'b101, 3'b110: op = OP_MM;
      default:        op = OP_NOP;
    endcase
    return op;
  endfunction

  // Output decode: {clr_a,carga_a,carga_q,carga_m,desplaza,resta,sel_m2,busy,done}
  function automatic logic [8:0] decode(input logic [2:0] st, input logic [2:0] op);
    logic [8:0] o;
    case (st)
      S_LOAD:  o = 9'b1_1_1_1_0_0_0_1_0;
      S_EVAL:  o = 9'b0_0_0_0_0_0_0_1_0;
      S_ADD:   o = {7'b0_1_0_0_0_0_0, 2'b10} | {5'b0_0_0_0_0, op[1], op[0], 2'b00};
      S_SHIFT: o = 9'b0_0_0_0_1_0_0_1_0;
      S_DONE:  o = 9'b0_0_0_0_0_0_0_1_1;
      default: o = 9'b0_0_0_0_0_0_0_0_0;
    endcase
    return o;
  endfunction

  // Next-state, iteration counter and recoded-op logic
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        w_count_nxt = {CNT_W{1'b0}};
        w_op_nxt    = OP_NOP;
        w_state_nxt = S_EVAL;
      end
      S_EVAL: begin
        w_op_nxt = recode(q_bits);
        if (w_op_nxt[2]) begin
          w_state_nxt = S_ADD;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_ADD: begin
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        // exit on the last iteration so the counter never wraps
        if (r_count == LAST_CNT) begin
          w_state_nxt = S_DONE;
        end else begin
          w_count_nxt = r_count + CNT_W'(1);
          w_state_nxt = S_EVAL;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_op_nxt    = OP_NOP;
        w_count_nxt = {CNT_W{1'b0}};
      end
    endcase
  end

  // State registers; outputs are decoded from the next state so they are
  // registered yet still aligned with the state they belong to
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_NOP;
      r_count <= {CNT_W{1'b0}};
      r_outs  <= 9'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_count <= w_count_nxt;
      r_outs  <= decode(w_state_nxt, w_op_nxt);
    end
  end

  assign {clr_a, carga_a, carga_q, carga_m, desplaza, resta, sel_m2, busy, done} = r_outs;

endmodule

// File: tb/tb_control_booth_r4.sv
module tb_control_booth_r4;

  // {clr_a,carga_a,carga_q,carga_m,desplaza,resta,sel_m2,busy,done}
  localparam logic [8:0] V_IDLE  = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] V_LOAD  = 9'b1_1_1_1_0_0_0_1_0;
  localparam logic [8:0] V_EVAL  = 9'b0_0_0_0_0_0_0_1_0;
  localparam logic [8:0] V_PM    = 9'b0_1_0_0_0_0_0_1_0;
  localparam logic [8:0] V_P2M   = 9'b0_1_0_0_0_0_1_1_0;
  localparam logic [8:0] V_M2M   = 9'b0_1_0_0_0_1_1_1_0;
  localparam logic [8:0] V_MM    = 9'b0_1_0_0_0_1_0_1_0;
  localparam logic [8:0] V_SHIFT = 9'b0_0_0_0_1_0_0_1_0;
  localparam logic [8:0] V_DONE  = 9'b0_0_0_0_0_0_0_1_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, start, start6;
  logic [2:0] q_bits, q6;
  logic clr_a, carga_a, carga_q, carga_m, desplaza, resta, sel_m2, busy, done;
  logic clr_a6, carga_a6, carga_q6, carga_m6, desplaza6, resta6, sel_m26, busy6, done6;
  logic [8:0] outs;
  assign outs = {clr_a, carga_a, carga_q, carga_m, desplaza, resta, sel_m2, busy, done};

  control_booth_r4 #(.N(4), .CNT_W(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .q_bits(q_bits),
    .clr_a(clr_a), .carga_a(carga_a), .carga_q(carga_q), .carga_m(carga_m),
    .desplaza(desplaza), .resta(resta), .sel_m2(sel_m2), .busy(busy), .done(done));

  control_booth_r4 #(.N(6), .CNT_W(2)) u_dut6 (
    .clk(clk), .reset_n(reset_n), .start(start6), .q_bits(q6),
    .clr_a(clr_a6), .carga_a(carga_a6), .carga_q(carga_q6), .carga_m(carga_m6),
    .desplaza(desplaza6), .resta(resta6), .sel_m2(sel_m26), .busy(busy6), .done(done6));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int exp6_q[$];
  int adds, shifts;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_chk(input string nm, input logic [8:0] e);
    step();
    chk(nm, {23'd0, outs}, {23'd0, e});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; start6 = 1'b0; q_bits = 3'b000; q6 = 3'b010;
    repeat (2) @(negedge clk);
    chk("reset_outs", {23'd0, outs}, 32'd0);
    reset_n = 1'b1;
    step_chk("idle_after_reset", V_IDLE);

    // done monitors: pop the expected done cycle whenever done is seen
    fork
      forever begin
        @(negedge clk);
        if (done) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL done_unexpected: got done=1 required done=0 (cycle %0d)", cyc);
          end else begin
            chk("done_cycle", cyc, exp_q.pop_front());
          end
        end
      end
      forever begin
        @(negedge clk);
        if (done6) begin
          if (exp6_q.size() == 0) begin
            total++; bad++;
            $display("FAIL done6_unexpected: got done=1 required done=0 (cycle %0d)", cyc);
          end else begin
            chk("done6_cycle", cyc, exp6_q.pop_front());
          end
        end
      end
    join_none

    // T1: reset in the middle of an ADD aborts without done
    start = 1'b1; q_bits = 3'b001;
    step_chk("t1_load", V_LOAD);
    start = 1'b0;
    step_chk("t1_eval", V_EVAL);
    step_chk("t1_add", V_PM);
    reset_n = 1'b0;
    #1;
    chk("t1_async_reset", {23'd0, outs}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step();
    chk("t1_idle", {23'd0, outs}, {23'd0, V_IDLE});

    // T2: all NOP -> 6-cycle latency, carga_a only in LOAD
    start = 1'b1; q_bits = 3'b000; exp_q.push_back(cyc + 6);
    step_chk("t2_load", V_LOAD);
    start = 1'b0;
    step_chk("t2_eval0", V_EVAL);
    step_chk("t2_shift0", V_SHIFT);
    step_chk("t2_eval1", V_EVAL);
    step_chk("t2_shift1", V_SHIFT);
    step_chk("t2_done", V_DONE);
    step_chk("t2_idle", V_IDLE);

    // T3: 011 -> +2M, then NOP -> 7 cycles
    start = 1'b1; exp_q.push_back(cyc + 7);
    step_chk("t3_load", V_LOAD);
    start = 1'b0;
    step_chk("t3_eval0", V_EVAL);
    q_bits = 3'b011;
    step_chk("t3_add_p2m", V_P2M);
    q_bits = 3'b000;
    step_chk("t3_shift0", V_SHIFT);
    step_chk("t3_eval1", V_EVAL);
    step_chk("t3_shift1", V_SHIFT);
    step_chk("t3_done", V_DONE);
    step_chk("t3_idle", V_IDLE);

    // T4: 100 -> -2M, 101 -> -M, 8 cycles
    start = 1'b1; exp_q.push_back(cyc + 8);
    step_chk("t4_load", V_LOAD);
    start = 1'b0;
    step_chk("t4_eval0", V_EVAL);
    q_bits = 3'b100;
    step_chk("t4_add_m2m", V_M2M);
    q_bits = 3'b000;
    step_chk("t4_shift0", V_SHIFT);
    step_chk("t4_eval1", V_EVAL);
    q_bits = 3'b101;
    step_chk("t4_add_mm", V_MM);
    q_bits = 3'b000;
    step_chk("t4_shift1", V_SHIFT);
    step_chk("t4_done", V_DONE);
    step_chk("t4_idle", V_IDLE);

    // T5a: start during EVAL/SHIFT is ignored
    start = 1'b1; exp_q.push_back(cyc + 6);
    step_chk("t5_load", V_LOAD);
    start = 1'b0;
    step_chk("t5_eval0", V_EVAL);
    start = 1'b1;
    step_chk("t5_shift0", V_SHIFT);
    start = 1'b0;
    step_chk("t5_eval1", V_EVAL);
    step_chk("t5_shift1", V_SHIFT);
    step_chk("t5_done", V_DONE);
    step_chk("t5_idle", V_IDLE);

    // T5b: start held high -> back-to-back runs, one IDLE between them
    start = 1'b1; exp_q.push_back(cyc + 6); exp_q.push_back(cyc + 13);
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 6) chk("t5b_done1", {23'd0, outs}, {23'd0, V_DONE});
      if (i == 7) chk("t5b_gap_idle", {23'd0, outs}, {23'd0, V_IDLE});
      if (i == 8) chk("t5b_load2", {23'd0, outs}, {23'd0, V_LOAD});
    end
    start = 1'b0;
    repeat (7) step();
    chk("t5b_idle_end", {23'd0, outs}, {23'd0, V_IDLE});

    // T6: N=6, all 010 -> 3 ADD, 3 SHIFT, done in cycle 11
    start6 = 1'b1; exp6_q.push_back(cyc + 11);
    step();
    start6 = 1'b0;
    adds = 0; shifts = 0;
    for (int i = 0; i < 14; i++) begin
      if (done6) break;
      if (carga_a6 && !carga_q6) adds++;
      if (desplaza6) shifts++;
      step();
    end
    chk("t6_done_seen", {31'd0, done6}, 32'd1);
    chk("t6_add_count", adds, 3);
    chk("t6_shift_count", shifts, 3);

    repeat (4) step();
    chk("sb_drain", exp_q.size(), 0);
    chk("sb6_drain", exp6_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
